cmos_gray_packer: RTL and testbench

CMOS_GRAY_PACKER -- requirements
Module: cmos_gray_packer

---
 rtl/cmos_gray_packer_pkg.sv | 31 +++
 rtl/cmos_gray_packer_fifo.sv | 81 ++++++++
 rtl/cmos_gray_packer.sv | 211 +++++++++++++++++++++
 tb/tb_cmos_gray_packer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cmos_gray_packer_pkg.sv
// -----------------------------------------------------------------------------
// cmos_gray_packer_pkg
// Shared constants, types and helpers for the CMOS gray-pixel packer.
//   PIX_PER_WORD : pixels packed into one output word (little-endian bytes)
//   CNT_W        : width of the line/pixel/frame counters (saturating)
//   fifo_word_t  : output FIFO word layout {sof, eol, data[31:0]}
// -----------------------------------------------------------------------------
package cmos_gray_packer_pkg;

    localparam int PIX_PER_WORD = 4;
    localparam int PIX_W        = 8;
    localparam int DATA_W       = PIX_PER_WORD * PIX_W;
    localparam int IDX_W        = $clog2(PIX_PER_WORD);
    localparam int CNT_W        = 12;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic              sof;
        logic              eol;
        logic [DATA_W-1:0] data;
    } fifo_word_t;

    localparam int WORD_W = $bits(fifo_word_t);

    // Counters stick at all-ones instead of wrapping.
    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == '1) ? v : v + cnt_t'(1);
    endfunction

endpackage

// File: rtl/cmos_gray_packer_fifo.sv
// -----------------------------------------------------------------------------
// gray_word_fifo
// First-word-fall-through FIFO with a registered output stage. A written word
// becomes visible on rd_data two clocks after the write is presented, because
// it passes through the storage array and then the output register.
// Total capacity (array + output register) is exactly DEPTH words.
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_en      : write wr_data (caller guarantees !full or a same-cycle pop)
//   rd_ready   : consumer accepts rd_data when !empty
//   full       : DEPTH words held
//   empty      : output register holds no word
// -----------------------------------------------------------------------------
module gray_word_fifo #(
    parameter int W     = 34,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_ready,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] mem_cnt_q, mem_cnt_d;
    logic [W-1:0]  dout_q, dout_d;
    logic          valid_q, valid_d;
    logic          pop, load;

    always_comb begin
        pop       = valid_q && rd_ready;
        // Refill the output register whenever it is empty or being drained.
        load      = (!valid_q || pop) && (mem_cnt_q != '0);
        wr_ptr_d  = wr_ptr_q + AW'(wr_en);
        rd_ptr_d  = rd_ptr_q + AW'(load);
        mem_cnt_d = mem_cnt_q + CW'(wr_en) - CW'(load);
        dout_d    = dout_q;
        valid_d   = valid_q;
        if (load) begin
            dout_d  = mem_q[rd_ptr_q];
            valid_d = 1'b1;
        end else if (pop) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            mem_cnt_q <= '0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            mem_cnt_q <= mem_cnt_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
        end
    end

    assign rd_data = dout_q;
    assign empty   = !valid_q;
    assign full    = (mem_cnt_q + CW'(valid_q)) == CW'(DEPTH);

endmodule

// File: rtl/cmos_gray_packer.sv
// -----------------------------------------------------------------------------
// cmos_gray_packer
// Packs an 8-bit gray CMOS pixel stream (vsync/href framing) into 32-bit words,
// four pixels per word little-endian, tagged with start-of-frame and
// end-of-line, and buffers them in a FWFT FIFO with a valid/ready output.
//   cmos_pclk, rst_n          : sole clock, asynchronous active-low reset
//   cmos_frame_vsync/href/data: camera input, one pixel per cycle while href
//   out_data/out_valid/out_ready/out_sof/out_eol : packed word stream
//   frame_width, frame_lines  : last line length / line count of last frame
//   line_err, overflow        : sticky status, cleared only by reset
// -----------------------------------------------------------------------------
module cmos_gray_packer
    import cmos_gray_packer_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                cmos_pclk,
    input  logic                rst_n,
    input  logic                cmos_frame_vsync,
    input  logic                cmos_frame_href,
    input  logic [PIX_W-1:0]    cmos_frame_data,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_sof,
    output logic                out_eol,
    output logic [CNT_W-1:0]    frame_width,
    output logic [CNT_W-1:0]    frame_lines,
    output logic                line_err,
    output logic                overflow
);

    localparam int BUF_W = PIX_W * (PIX_PER_WORD - 1);

    logic              vsync_q, vsync_d;
    logic              href_q, href_d;
    logic              edge_ok_q, edge_ok_d;
    logic              frame_en_q, frame_en_d;
    cnt_t              pix_cnt_q, pix_cnt_d;
    cnt_t              line_cnt_q, line_cnt_d;
    cnt_t              last_w_q, last_w_d;
    cnt_t              frame_width_q, frame_width_d;
    cnt_t              frame_lines_q, frame_lines_d;
    logic [IDX_W-1:0]  pack_idx_q, pack_idx_d;
    logic [BUF_W-1:0]  pack_buf_q, pack_buf_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic              push_full_q, push_full_d;
    logic              sof_arm_q, sof_arm_d;
    logic              drop_q, drop_d;
    logic              line_err_q, line_err_d;
    logic              overflow_q, overflow_d;

    logic              vs_rise, vs_fall, hfall, sample, pop, push_req, fifo_wr;
    fifo_word_t        push_word, rd_word;
    logic [WORD_W-1:0] fifo_rd_data;
    logic              fifo_full, fifo_empty;

    always_comb begin
        // edge_ok_q stays low for the first clock after reset so that a vsync
        // already high at release is not mistaken for a frame start.
        vs_rise = cmos_frame_vsync && !vsync_q && edge_ok_q;
        vs_fall = !cmos_frame_vsync && vsync_q && frame_en_q;
        hfall   = href_q && !cmos_frame_href && frame_en_q;
        sample  = cmos_frame_vsync && cmos_frame_href && (frame_en_q || vs_rise);
        pop     = out_valid && out_ready;

        // A full group is pushed one cycle after its 4th pixel; by then href
        // shows whether that pixel closed the line.
        push_req       = push_full_q || (hfall && (pack_idx_q != '0));
        push_word.sof  = sof_arm_q;
        push_word.eol  = push_full_q ? !cmos_frame_href : 1'b1;
        push_word.data = push_full_q ? word_q : {{PIX_W{1'b0}}, pack_buf_q};
        fifo_wr        = push_req && !drop_q && (!fifo_full || pop);

        vsync_d       = cmos_frame_vsync;
        href_d        = cmos_frame_href;
        edge_ok_d     = 1'b1;
        frame_en_d    = frame_en_q;
        pix_cnt_d     = pix_cnt_q;
        line_cnt_d    = line_cnt_q;
        last_w_d      = last_w_q;
        frame_width_d = frame_width_q;
        frame_lines_d = frame_lines_q;
        pack_idx_d    = pack_idx_q;
        pack_buf_d    = pack_buf_q;
        word_d        = word_q;
        push_full_d   = 1'b0;
        sof_arm_d     = sof_arm_q;
        drop_d        = drop_q;
        line_err_d    = line_err_q;
        overflow_d    = overflow_q;

        if (push_req) begin
            sof_arm_d = 1'b0;
            if (!drop_q && fifo_full && !pop) begin
                overflow_d = 1'b1;
                drop_d     = 1'b1;
            end
        end

        if (hfall) begin
            if (pix_cnt_q != cnt_t'(IMG_WIDTH)) begin
                line_err_d = 1'b1;
            end
            last_w_d   = pix_cnt_q;
            line_cnt_d = sat_inc(line_cnt_q);
            pix_cnt_d  = '0;
            pack_idx_d = '0;
            pack_buf_d = '0;
        end

        if (vs_rise) begin
            frame_en_d = 1'b1;
            pix_cnt_d  = '0;
            line_cnt_d = '0;
            pack_idx_d = '0;
            pack_buf_d = '0;
            drop_d     = 1'b0;
            sof_arm_d  = 1'b1;
        end

        if (vs_fall) begin
            frame_en_d    = 1'b0;
            frame_width_d = last_w_d;
            frame_lines_d = line_cnt_d;
        end

        if (sample) begin
            pix_cnt_d = sat_inc(pix_cnt_d);
            if (pack_idx_d == IDX_W'(PIX_PER_WORD - 1)) begin
                word_d      = {cmos_frame_data, pack_buf_d};
                push_full_d = 1'b1;
                pack_buf_d  = '0;
                pack_idx_d  = '0;
            end else begin
                case (pack_idx_d)
                    2'd0:    pack_buf_d[7:0]   = cmos_frame_data;
                    2'd1:    pack_buf_d[15:8]  = cmos_frame_data;
                    default: pack_buf_d[23:16] = cmos_frame_data;
                endcase
                pack_idx_d = pack_idx_d + 2'd1;
            end
        end
    end

    always_ff @(posedge cmos_pclk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q       <= 1'b0;
            href_q        <= 1'b0;
            edge_ok_q     <= 1'b0;
            frame_en_q    <= 1'b0;
            pix_cnt_q     <= '0;
            line_cnt_q    <= '0;
            last_w_q      <= '0;
            frame_width_q <= '0;
            frame_lines_q <= '0;
            pack_idx_q    <= '0;
            pack_buf_q    <= '0;
            word_q        <= '0;
            push_full_q   <= 1'b0;
            sof_arm_q     <= 1'b0;
            drop_q        <= 1'b0;
            line_err_q    <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            vsync_q       <= vsync_d;
            href_q        <= href_d;
            edge_ok_q     <= edge_ok_d;
            frame_en_q    <= frame_en_d;
            pix_cnt_q     <= pix_cnt_d;
            line_cnt_q    <= line_cnt_d;
            last_w_q      <= last_w_d;
            frame_width_q <= frame_width_d;
            frame_lines_q <= frame_lines_d;
            pack_idx_q    <= pack_idx_d;
            pack_buf_q    <= pack_buf_d;
            word_q        <= word_d;
            push_full_q   <= push_full_d;
            sof_arm_q     <= sof_arm_d;
            drop_q        <= drop_d;
            line_err_q    <= line_err_d;
            overflow_q    <= overflow_d;
        end
    end

    gray_word_fifo #(
        .W     (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (cmos_pclk),
        .rst_n    (rst_n),
        .wr_en    (fifo_wr),
        .wr_data  (push_word),
        .rd_ready (out_ready),
        .rd_data  (fifo_rd_data),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign rd_word     = fifo_rd_data;
    assign out_valid   = !fifo_empty;
    assign out_data    = rd_word.data;
    assign out_sof     = rd_word.sof;
    assign out_eol     = rd_word.eol;
    assign frame_width = frame_width_q;
    assign frame_lines = frame_lines_q;
    assign line_err    = line_err_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_cmos_gray_packer.sv
module tb_cmos_gray_packer;

    logic        clk;
    logic        rst_n;
    logic        vsync;
    logic        href;
    logic [7:0]  din;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sof;
    logic        out_eol;
    logic [11:0] frame_width;
    logic [11:0] frame_lines;
    logic        line_err;
    logic        overflow;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [33:0] got_q[$];
    bit          toggle_mode = 0;
    bit          held_v = 0;
    logic [33:0] held_w;

    cmos_gray_packer #(
        .IMG_WIDTH  (8),
        .FIFO_DEPTH (16)
    ) dut (
        .cmos_pclk        (clk),
        .rst_n            (rst_n),
        .cmos_frame_vsync (vsync),
        .cmos_frame_href  (href),
        .cmos_frame_data  (din),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_sof          (out_sof),
        .out_eol          (out_eol),
        .frame_width      (frame_width),
        .frame_lines      (frame_lines),
        .line_err         (line_err),
        .overflow         (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input int idx, input logic sof,
                              input logic eol, input logic [31:0] data);
        logic [33:0] obs;
        obs = 'x;
        if (idx < got_q.size()) obs = got_q[idx];
        check(tag, 64'(obs), 64'({sof, eol, data}));
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (toggle_mode) out_ready = !out_ready;
        end
    endtask

    task automatic send_line(input int n, input logic [7:0] first, input int gap);
        for (int i = 0; i < n; i++) begin
            href = 1'b1;
            din  = first + 8'(i);
            tick(1);
        end
        href = 1'b0;
        din  = 8'h00;
        tick(gap);
    endtask

    // Capture accepted words; while stalled, the presented word must not move.
    always @(negedge clk) begin
        if (rst_n) begin
            if (held_v) check("stall_hold", 64'({out_valid, out_sof, out_eol, out_data}),
                              64'({1'b1, held_w}));
            if (out_valid && out_ready) got_q.push_back({out_sof, out_eol, out_data});
            held_v = out_valid && !out_ready;
            held_w = {out_sof, out_eol, out_data};
        end else begin
            held_v = 0;
        end
    end

    initial begin
        rst_n = 1'b0; vsync = 1'b0; href = 1'b0; din = 8'h00; out_ready = 1'b0;
        #25;
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_data", 64'(out_data), 64'(0));
        check("rst_fw", 64'(frame_width), 64'(0));
        check("rst_fl", 64'(frame_lines), 64'(0));
        check("rst_flags", 64'({line_err, overflow, out_sof, out_eol}), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick(3);

        // Two 8-pixel lines, always ready.
        vsync = 1'b1; tick(2);
        send_line(8, 8'h00, 4);
        send_line(8, 8'h08, 4);
        vsync = 1'b0; tick(6);
        check("f1_count", 64'(got_q.size()), 64'(4));
        check_word("f1_w0", 0, 1'b1, 1'b0, 32'h03020100);
        check_word("f1_w1", 1, 1'b0, 1'b1, 32'h07060504);
        check_word("f1_w2", 2, 1'b0, 1'b0, 32'h0B0A0908);
        check_word("f1_w3", 3, 1'b0, 1'b1, 32'h0F0E0D0C);
        check("f1_lines", 64'(frame_lines), 64'(2));
        check("f1_width", 64'(frame_width), 64'(8));
        check("f1_line_err", 64'(line_err), 64'(0));
        got_q.delete();

        // Short 6-pixel line: zero-padded partial word, line error.
        vsync = 1'b1; tick(2);
        send_line(6, 8'hA1, 4);
        vsync = 1'b0; tick(6);
        check("short_count", 64'(got_q.size()), 64'(2));
        check_word("short_w0", 0, 1'b1, 1'b0, 32'hA4A3A2A1);
        check_word("short_w1", 1, 1'b0, 1'b1, 32'h0000A6A5);
        check("short_line_err", 64'(line_err), 64'(1));
        check("short_width", 64'(frame_width), 64'(6));
        check("short_lines", 64'(frame_lines), 64'(1));
        got_q.delete();

        // href activity outside a frame is ignored.
        send_line(5, 8'hC0, 3);
        send_line(8, 8'hC8, 3);
        tick(6);
        check("novs_count", 64'(got_q.size()), 64'(0));
        check("novs_lines", 64'(frame_lines), 64'(1));
        check("novs_width", 64'(frame_width), 64'(6));
        check("novs_valid", 64'(out_valid), 64'(0));

        // Ready toggling every cycle: in-order, no loss, held while stalled.
        toggle_mode = 1;
        vsync = 1'b1; tick(2);
        send_line(8, 8'h10, 4);
        send_line(8, 8'h18, 4);
        vsync = 1'b0; tick(10);
        toggle_mode = 0;
        out_ready = 1'b1;
        tick(6);
        check("tog_count", 64'(got_q.size()), 64'(4));
        check_word("tog_w0", 0, 1'b1, 1'b0, 32'h13121110);
        check_word("tog_w1", 1, 1'b0, 1'b1, 32'h17161514);
        check_word("tog_w2", 2, 1'b0, 1'b0, 32'h1B1A1918);
        check_word("tog_w3", 3, 1'b0, 1'b1, 32'h1F1E1D1C);
        check("tog_overflow", 64'(overflow), 64'(0));
        got_q.delete();

        // 640x4 frame with the consumer stalled: FIFO fills, rest dropped.
        out_ready = 1'b0;
        vsync = 1'b1; tick(2);
        for (int l = 0; l < 4; l++) send_line(640, 8'h00, 4);
        vsync = 1'b0; tick(6);
        check("ovf_flag", 64'(overflow), 64'(1));
        check("ovf_width", 64'(frame_width), 64'(640));
        check("ovf_lines", 64'(frame_lines), 64'(4));
        check("ovf_head", 64'({out_valid, out_sof, out_eol, out_data}),
              64'({1'b1, 1'b1, 1'b0, 32'h03020100}));
        out_ready = 1'b1;
        tick(40);
        check("ovf_count", 64'(got_q.size()), 64'(16));
        for (int k = 0; k < 16; k++) begin
            logic [7:0] b;
            b = 8'(4 * k);
            check_word("ovf_word", k, (k == 0), 1'b0, {b + 8'd3, b + 8'd2, b + 8'd1, b});
        end
        got_q.delete();
        vsync = 1'b1; tick(2);
        send_line(8, 8'h50, 4);
        vsync = 1'b0; tick(6);
        check("post_ovf_count", 64'(got_q.size()), 64'(2));
        check_word("post_ovf_w0", 0, 1'b1, 1'b0, 32'h53525150);
        check_word("post_ovf_w1", 1, 1'b0, 1'b1, 32'h57565554);
        got_q.delete();

        // Reset mid-line, release mid-frame.
        vsync = 1'b1; tick(2);
        send_line(8, 8'h20, 6);
        href = 1'b1; din = 8'h30; tick(1);
        din = 8'h31; tick(1);
        din = 8'h32; tick(1);
        rst_n = 1'b0;
        #1;
        check("mrst_out", 64'({out_valid, out_sof, out_eol, out_data}), 64'(0));
        check("mrst_counts", 64'({frame_width, frame_lines}), 64'(0));
        check("mrst_flags", 64'({line_err, overflow}), 64'(0));
        got_q.delete();
        din = 8'h33; tick(1);
        din = 8'h34; tick(1);
        rst_n = 1'b1;
        din = 8'h35; tick(1);
        din = 8'h36; tick(1);
        din = 8'h37; tick(1);
        href = 1'b0; tick(4);
        send_line(8, 8'h38, 4);
        vsync = 1'b0; tick(6);
        check("mrst_nowords", 64'(got_q.size()), 64'(0));
        check("mrst_lines_kept", 64'(frame_lines), 64'(0));
        vsync = 1'b1; tick(2);
        send_line(8, 8'h60, 4);
        vsync = 1'b0; tick(6);
        check("mrst_count", 64'(got_q.size()), 64'(2));
        check_word("mrst_w0", 0, 1'b1, 1'b0, 32'h63626160);
        check_word("mrst_w1", 1, 1'b0, 1'b1, 32'h67666564);
        check("mrst_width", 64'(frame_width), 64'(8));
        check("mrst_lines", 64'(frame_lines), 64'(1));
        check("mrst_line_err", 64'(line_err), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
